// File: rtl/picmicro_intcon_pkg.sv
// Shared INTCON definitions for the midrange interrupt controller: bit positions,
// reset value, nesting-state encoding and the pending-interrupt helper.
package picmicro_intcon_pkg;

    localparam int GIE  = 7;
    localparam int PEIE = 6;
    localparam int T0IE = 5;
    localparam int INTE = 4;
    localparam int RBIE = 3;
    localparam int T0IF = 2;
    localparam int INTF = 1;
    localparam int RBIF = 0;

    localparam logic [8:0] INTCON_ADDR = 9'h00B;
    localparam logic [7:0] INTCON_RST  = 8'h00;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ISR  = 1'b1
    } nest_state_e;

    // Any enabled source flagged, ignoring GIE.
    function automatic logic intcon_pend(input logic [7:0] ic, input logic periph);
        return (ic[T0IE] & ic[T0IF]) | (ic[INTE] & ic[INTF]) |
               (ic[RBIE] & ic[RBIF]) | (ic[PEIE] & periph);
    endfunction

endpackage

// File: rtl/picmicro_interrupt_controller_if.sv
// Core-facing INTCON register port and interrupt vector/RETFIE handshake.
interface picmicro_interrupt_controller_if;

    logic       intcon_wr_en;
    logic [7:0] intcon_wr_data;
    logic [7:0] intcon_out;
    logic       irq_req;
    logic       irq_ack;
    logic       retfie;
    logic       wake;
    logic       in_isr;

    modport master (
        output intcon_wr_en, intcon_wr_data, irq_ack, retfie,
        input  intcon_out, irq_req, wake, in_isr
    );

    modport slave (
        input  intcon_wr_en, intcon_wr_data, irq_ack, retfie,
        output intcon_out, irq_req, wake, in_isr
    );

endinterface

// File: rtl/picmicro_edge_sync.sv
// Two-flop synchronizer with a previous-value stage; rise/fall are decoded from the
// synchronized value so edges appear one cycle after the value is stable.
module picmicro_edge_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;
    logic [WIDTH-1:0] prev_r;

    // Synchronizer chain and previous-value register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
            prev_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign sync = sync_r;
    assign rise = sync_r & ~prev_r;
    assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/picmicro_interrupt_controller.sv
// INTCON owner: latches T0/INT/PORTB-change/peripheral events, raises irq_req and
// tracks interrupt nesting depth across irq_ack / RETFIE.
module picmicro_interrupt_controller
    import picmicro_intcon_pkg::*;
#(
    parameter int NEST_MAX = 7
) (
    input  logic                           clk,
    input  logic                           rst_n,
    picmicro_interrupt_controller_if.slave bus,
    input  logic                           intedg,
    input  logic                           int_pin,
    input  logic [3:0]                     rb_in,
    input  logic                           rb_port_read,
    input  logic                           t0_overflow,
    input  logic                           periph_irq
);

    localparam logic [2:0] NEST_SAT = 3'(NEST_MAX);

    logic [7:0]  intcon_r;
    logic [7:0]  intcon_nxt_s;
    logic [2:0]  depth_r;
    logic [2:0]  depth_nxt_s;
    nest_state_e state_r;
    nest_state_e state_nxt_s;
    logic [3:0]  rb_latch_r;
    logic [3:0]  rb_latch_nxt_s;

    logic        int_sync_s;
    logic        int_rise_s;
    logic        int_fall_s;
    logic [3:0]  rb_sync_s;
    logic [3:0]  rb_rise_s;
    logic [3:0]  rb_fall_s;
    logic        unused_s;

    logic        pend_s;
    logic        irq_req_s;
    logic        ack_ok_s;
    logic        int_evt_s;
    logic        rb_evt_s;

    picmicro_edge_sync #(.WIDTH(1)) u_int_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (int_pin),
        .sync  (int_sync_s),
        .rise  (int_rise_s),
        .fall  (int_fall_s)
    );

    picmicro_edge_sync #(.WIDTH(4)) u_rb_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (rb_in),
        .sync  (rb_sync_s),
        .rise  (rb_rise_s),
        .fall  (rb_fall_s)
    );

    // PORTB change is a level compare against the latch, not an edge.
    assign unused_s = ^{int_sync_s, rb_rise_s, rb_fall_s};

    // Request decode and event qualification.
    always_comb begin
        pend_s    = intcon_pend(intcon_r, periph_irq);
        irq_req_s = intcon_r[GIE] & pend_s;
        ack_ok_s  = bus.irq_ack & irq_req_s;
        int_evt_s = intedg ? int_rise_s : int_fall_s;
        rb_evt_s  = (rb_sync_s != rb_latch_r);
    end

    // INTCON next value: software write, then GIE handshake, then hardware flag sets.
    always_comb begin
        intcon_nxt_s   = intcon_r;
        rb_latch_nxt_s = rb_latch_r;
        if (bus.intcon_wr_en) begin
            intcon_nxt_s = bus.intcon_wr_data;
        end else begin
            intcon_nxt_s = intcon_r;
        end
        if (ack_ok_s) begin
            intcon_nxt_s[GIE] = 1'b0;
        end else if (bus.retfie) begin
            intcon_nxt_s[GIE] = 1'b1;
        end else begin
            intcon_nxt_s[GIE] = intcon_nxt_s[GIE];
        end
        intcon_nxt_s[T0IF] = intcon_nxt_s[T0IF] | t0_overflow;
        intcon_nxt_s[INTF] = intcon_nxt_s[INTF] | int_evt_s;
        intcon_nxt_s[RBIF] = intcon_nxt_s[RBIF] | rb_evt_s;
        if (rb_port_read) begin
            rb_latch_nxt_s = rb_sync_s;
        end else begin
            rb_latch_nxt_s = rb_latch_r;
        end
    end

    // Nesting FSM: depth saturates at both ends; ack wins over retfie.
    always_comb begin
        state_nxt_s = state_r;
        depth_nxt_s = depth_r;
        case (state_r)
            ST_IDLE: begin
                if (ack_ok_s) begin
                    state_nxt_s = ST_ISR;
                    depth_nxt_s = 3'd1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    depth_nxt_s = 3'd0;
                end
            end
            ST_ISR: begin
                if (ack_ok_s) begin
                    depth_nxt_s = (depth_r < NEST_SAT) ? depth_r + 3'd1 : depth_r;
                end else if (bus.retfie) begin
                    depth_nxt_s = depth_r - 3'd1;
                    state_nxt_s = (depth_r == 3'd1) ? ST_IDLE : ST_ISR;
                end else begin
                    depth_nxt_s = depth_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                depth_nxt_s = 3'd0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intcon_r   <= INTCON_RST;
            depth_r    <= 3'd0;
            state_r    <= ST_IDLE;
            rb_latch_r <= 4'h0;
        end else begin
            intcon_r   <= intcon_nxt_s;
            depth_r    <= depth_nxt_s;
            state_r    <= state_nxt_s;
            rb_latch_r <= rb_latch_nxt_s;
        end
    end

    assign bus.intcon_out = intcon_r;
    assign bus.irq_req    = irq_req_s;
    assign bus.wake       = pend_s;
    assign bus.in_isr     = (state_r == ST_ISR);

endmodule

// File: doc/picmicro_interrupt_controller.md
# picmicro_interrupt_controller

Interrupt source and INTCON owner for the midrange core. Latches T0, external INT (RB0), PORTB-change and peripheral events into INTCON flags and raises `irq_req` toward the core. The core answers with `irq_ack` when it vectors to 0x0004, which clears GIE. It answers with `retfie` on return, which sets GIE. This block is the responder side of the core's interrupt-vector/RETFIE control flow.

## Interface
Parameters:
- `NEST_MAX`, 7: saturation value of the nesting depth counter (3-bit).

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `intcon_wr_en`  in  1  core write strobe to INTCON (addr 0x0B, all banks).
- `intcon_wr_data`  in  8  write data.
- `intcon_out`  out  8  current INTCON: GIE7 PEIE6 T0IE5 INTE4 RBIE3 T0IF2 INTF1 RBIF0.
- `intedg`  in  1  OPTION_REG bit 6; 1 = rising edge on INT.
- `int_pin`  in  1  RB0/INT, asynchronous.
- `rb_in`  in  4  RB7:RB4 pins, asynchronous.
- `rb_port_read`  in  1  one-cycle pulse on a core read of PORTB.
- `t0_overflow`  in  1  one-cycle TMR0 overflow pulse.
- `periph_irq`  in  1  OR of (PIR1 & PIE1), synchronous.
- `irq_ack`  in  1  one-cycle pulse; the core has pushed the PC and is jumping to 0x0004.
- `retfie`  in  1  one-cycle pulse; the core executed RETFIE.
- `irq_req`  out  1  interrupt request to the core.
- `wake`  out  1  SLEEP wake request.
- `in_isr`  out  1  nesting depth ≠ 0.

## Operation
- `pend` = (T0IE&T0IF) | (INTE&INTF) | (RBIE&RBIF) | (PEIE&periph_irq).
- `irq_req` = GIE & pend. Combinational from registers and `periph_irq`. Held until acknowledged or the flag is cleared.
- `wake` = `pend`, independent of GIE.
- T0IF: set the cycle after a `t0_overflow` pulse.
- INTF: set on the synchronized edge selected by `intedg`. Changing `intedg` alone never sets INTF.
- RBIF:
  - Set every cycle in which the synchronized `rb_in` differs from `rb_latch`.
  - `rb_latch` loads the synchronized `rb_in` on `rb_port_read`.
- Nesting depth counter (states IDLE = depth 0, ISR = depth ≥ 1):
  - `irq_ack` while `irq_req` = 1 → GIE ← 0, depth +1, saturating at NEST_MAX.
  - `irq_ack` while `irq_req` = 0 → ignored entirely.
  - `retfie` → GIE ← 1, depth −1, saturating at 0.
  - `retfie` in IDLE still sets GIE.
- Priority within one cycle:
  - Hardware flag set beats a software write of 0 to that flag; no event is lost.
  - `irq_ack` GIE clear beats a software GIE write.
  - `irq_ack` beats `retfie` if both are asserted.
  - A software write is otherwise applied to all 8 bits.
- Reset (`rst_n` low, asynchronous, any time):
  - INTCON = 0x00, depth = 0.
  - Synchronizers = 0, `rb_latch` = 0.
  - Outputs `irq_req` = 0, `wake` = 0, `in_isr` = 0, `intcon_out` = 0x00.
  - Any request in flight is dropped.

## Timing
- `int_pin` / `rb_in`: 2-flop synchronizer, plus one registered previous-value stage.
- INTF and RBIF become visible 3 rising edges after the pin change is first sampled.
- T0IF becomes visible 1 edge after the `t0_overflow` pulse.
- `irq_req` and `wake` follow flag/enable changes in the same cycle; zero added latency.
- `intcon_wr_en` takes effect on the next edge.
- GIE/depth update on the edge that samples `irq_ack` or `retfie`. `irq_req` drops in the following cycle.
- The core samples `irq_req` only at instruction boundaries (4 clocks per instruction). This block imposes no additional handshake delay.

## Structure
- Package `picmicro_intcon_pkg`:
  - Bit-index localparams: GIE, PEIE, T0IE, INTE, RBIE, T0IF, INTF, RBIF.
  - `INTCON_ADDR` = 9'h00B.
  - `INTCON_RST` = 8'h00.
- Sub-module `picmicro_edge_sync`:
  - Parameterized width; 2-flop synchronizer plus previous-value register.
  - Outputs `sync`, `rise`, `fall`.
  - Instanced once for INT (width 1) and once for RB7:RB4 (width 4).

## Test plan
- Write INTCON=0xA0 (GIE, T0IE), pulse `t0_overflow` → T0IF=1 and `irq_req`=1 the next cycle. Pulse `irq_ack` → `intcon_out`=0x24, `in_isr`=1, `irq_req`=0. Write 0x20 (clear T0IF), pulse `retfie` → `intcon_out`=0xA0, `in_isr`=0.
- `intedg`=1, INTCON=0x90, raise `int_pin` → INTF=1 exactly 3 edges later, `irq_req`=1. With `intedg`=0 the rising edge leaves INTF=0, and the subsequent falling edge sets it.
- With `rb_latch`=0, drive `rb_in`=4'b1000 → RBIF=1 after 3 edges. Clear RBIF without `rb_port_read` → RBIF re-sets the next cycle. Pulse `rb_port_read`, then clear → RBIF stays 0.
- INTCON=0x30 (GIE=0), event on T0 → `wake`=1, `irq_req`=0. Pulse `irq_ack` → ignored: depth 0, INTCON unchanged.
- In the same cycle, `t0_overflow` sets T0IF and a software write clears T0IF → T0IF=1. `irq_ack` together with a write of GIE=1 → GIE=0.
- Assert `rst_n`=0 mid-ISR (depth 2, INTCON=0x2C) → all outputs 0 immediately, asynchronously. Release → INTCON=0x00 and events are counted fresh.
